kvs_mem_arbiter: RTL
====================

# kvs_mem_arbiter

Sequencer and two-client arbiter for the KVS single-port hash-table memory (`memory` instance, 1-cycle registered read, rd_en priority over wr_en, no clearing on reset). After reset, and on request, it sweeps the whole array to zero. It then shares the single port between two clients, port 0 for lookup and port 1 for update, using round-robin arbitration. It returns read data to the requesting client with fixed latency.

## Interface
Parameters:
- ADDR_WIDTH, 8, memory address width
- DATA_WIDTH, 256, memory word width
- MEM_DEPTH, 1 << ADDR_WIDTH, number of entries swept during init

Ports:
- clock  in  1  clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  pulse in RUN: re-zero the whole memory
- init_done  out  1  high in RUN state
- req_valid_k (k=0,1)  in  1  client k request valid
- req_ready_k  out  1  client k request accepted this cycle
- req_we_k  in  1  1 = write, 0 = read
- req_addr_k  in  ADDR_WIDTH  request address
- req_wdata_k  in  DATA_WIDTH  write data
- rsp_valid_k  out  1  read data valid for client k; one cycle per read
- rsp_data_k  out  DATA_WIDTH  read data
- mem_address  out  ADDR_WIDTH  to memory address
- mem_dataIn  out  DATA_WIDTH  to memory dataIn
- mem_rd_en  out  1  to memory rd_en
- mem_wr_en  out  1  to memory wr_en
- mem_q  in  DATA_WIDTH  from memory q

## Operation
- States: INIT, RUN. Reset enters INIT with the sweep counter at 0.
- INIT:
  - Each cycle: mem_wr_en=1, mem_address=counter, mem_dataIn=0. The counter then increments.
  - After the write of address MEM_DEPTH-1, the next state is RUN.
  - req_ready_k=0 throughout.
- RUN:
  - Grant is combinational from req_valid_0/1 and the round-robin pointer ptr (reset 0 = client 0 favoured).
  - When both clients are valid, client ptr wins. When only one is valid, it wins.
  - After any grant to k, ptr := 1-k. With no grant, ptr holds.
  - req_ready_k = RUN && !clear && grant_k.
  - A granted request drives the memory in the same cycle: mem_address=req_addr_k and mem_dataIn=req_wdata_k.
  - A read sets mem_rd_en=1. A write sets mem_wr_en=1.
  - mem_rd_en and mem_wr_en are never both high.
  - With no grant, mem_rd_en=mem_wr_en=0. mem_address and mem_dataIn hold their last value.
- Read return:
  - A 2-stage tag pipeline (valid plus client id) tracks each read.
  - Stage 2 registers mem_q into rsp_data_k of the tagged client and pulses rsp_valid_k.
  - rsp_data of the other client holds its value.
  - Responses have no backpressure; clients must sink them.
- Writes produce no response.
- clear high in RUN blocks all grants that cycle; the next state is INIT with the counter at 0.
  - Reads already issued complete normally with pre-clear data.
  - clear in INIT is ignored; the sweep does not restart.
- rst_n low at any time, including mid-sweep or with reads in flight:
  - Next cycle: state INIT, counter 0, ptr 0, pipeline flushed (no rsp_valid for those reads).
  - While rst_n is low: mem_rd_en=mem_wr_en=0.

## Timing
- Reset values:
  - init_done=0, rsp_valid_k=0, rsp_data_k=0, req_ready_k=0
  - mem_rd_en=0, mem_wr_en=0, mem_address=0, mem_dataIn=0
- Init duration: exactly MEM_DEPTH cycles after the first cycle with rst_n high. init_done rises in cycle MEM_DEPTH (256 by default).
- Read latency: accepted in cycle T (valid&ready), mem_q valid in T+1, rsp_valid_k high in T+2.
- Throughput: one request per cycle total. A lone client is granted every cycle. Two saturating clients alternate 0,1,0,1 from ptr.
- Write then read of the same address in consecutive cycles returns the new data, because the memory is sequential.
- A read in cycle T followed by a write in T+1 to the same address returns the old data.
- req_ready_k depends combinationally on req_valid_k. Clients must not derive req_valid from req_ready.

## Structure
- Package kvs_mem_pkg:
  - state enum (INIT, RUN)
  - NUM_CLIENTS=2 and the client-id type
  - read-tag struct (valid, id)
- Sub-module kvs_rr_arbiter (2-way round-robin: req[1:0] and advance in, grant[1:0] out, pointer held inside).
- Everything else (sweep counter, tag pipeline, memory muxing) lives in kvs_mem_arbiter.
- Bench instantiates kvs_mem_arbiter together with `memory` at default parameters.

## Test plan
- Reset, then idle: mem_wr_en high for exactly 256 cycles with addresses 0..255 and data 0. init_done rises in cycle 256. No req_ready before then.
- Client 0 writes 0xA5..A5 to addr 0x10 at T, then reads 0x10 at T+1: rsp_valid_0 high only at T+3 with rsp_data_0=0xA5..A5. rsp_valid_1 stays 0.
- Both clients read back-to-back for 8 cycles (client 0 at 0x00-0x07, client 1 at 0x80-0x87, preloaded): grants alternate 0,1,…. Each response returns 2 cycles after its grant, to the correct client with the correct data.
- clear asserted with two reads in flight: both reads return pre-clear data. No ready for 256+1 cycles. A read of a previously written address afterwards returns 0.
- rst_n low for 1 cycle at sweep address 100 with a read pending: no rsp_valid. The sweep restarts at address 0 and init_done rises 256 cycles after rst_n returns high.
- Client 1 alone requests every cycle for 20 cycles (mixed read/write): ready every cycle. mem_rd_en&mem_wr_en never both high (assertion kept active for the whole test).

Source files
------------

// File: rtl/kvs_mem_pkg.sv
// Shared types for the KVS memory sequencer/arbiter: FSM states, client ids
// and the read-tag record that follows each read through the return pipeline.
package kvs_mem_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int NUM_CLIENTS = 2;

   typedef logic [$clog2(NUM_CLIENTS)-1:0] client_id_t;

   typedef struct packed {
      logic       valid;
      client_id_t id;
   } rd_tag_t;

endpackage

// File: rtl/kvs_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer names the favoured client and
// moves past whichever client was granted when advance is high.
module kvs_rr_arbiter (
   input  logic       clock,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_reg;
   logic ptr_next;

   always_comb begin
      grant    = 2'b00;
      ptr_next = ptr_reg;
      if (req[0] && (!req[1] || !ptr_reg)) begin
         grant[0] = 1'b1;
      end else if (req[1]) begin
         grant[1] = 1'b1;
      end
      if (advance && grant[0]) begin
         ptr_next = 1'b1;
      end else if (advance && grant[1]) begin
         ptr_next = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         ptr_reg <= 1'b0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/memory.sv
// Single-port hash-table memory: registered read, read wins over write,
// contents are not cleared by any reset.
module memory #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 256
) (
   input  logic                  clock,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic                  rd_en,
   input  logic                  wr_en,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] mem_array [1 << ADDR_WIDTH];

   always_ff @(posedge clock) begin
      if (rd_en) begin
         q <= mem_array[address];
      end else if (wr_en) begin
         mem_array[address] <= dataIn;
      end
   end

endmodule

// File: rtl/kvs_mem_arbiter.sv
// Zero-sweeps the KVS memory after reset or clear, then shares its single port
// between the lookup (0) and update (1) clients with a fixed 2-cycle read return.
module kvs_mem_arbiter
   import kvs_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 256,
   parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  clear,
   output logic                  init_done,
   input  logic                  req_valid_0,
   output logic                  req_ready_0,
   input  logic                  req_we_0,
   input  logic [ADDR_WIDTH-1:0] req_addr_0,
   input  logic [DATA_WIDTH-1:0] req_wdata_0,
   output logic                  rsp_valid_0,
   output logic [DATA_WIDTH-1:0] rsp_data_0,
   input  logic                  req_valid_1,
   output logic                  req_ready_1,
   input  logic                  req_we_1,
   input  logic [ADDR_WIDTH-1:0] req_addr_1,
   input  logic [DATA_WIDTH-1:0] req_wdata_1,
   output logic                  rsp_valid_1,
   output logic [DATA_WIDTH-1:0] rsp_data_1,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_dataIn,
   output logic                  mem_rd_en,
   output logic                  mem_wr_en,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0] addr_hold_reg;
   logic [DATA_WIDTH-1:0] data_hold_reg;
   rd_tag_t               tag_s1_reg, tag_s1_next, tag_s2_reg;
   logic [DATA_WIDTH-1:0] rsp_data_reg [NUM_CLIENTS];
   logic [NUM_CLIENTS-1:0] rsp_valid_vec;

   logic                  run_en;
   logic [1:0]            req_vec;
   logic [1:0]            grant;
   logic                  gnt_any;
   logic                  gnt_we;
   client_id_t            gnt_id;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [DATA_WIDTH-1:0] gnt_wdata;

   // Masking the requests (not just the grants) keeps the pointer still while blocked.
   assign run_en  = rst_n && (state_reg == RUN) && !clear;
   assign req_vec = {req_valid_1 && run_en, req_valid_0 && run_en};

   kvs_rr_arbiter u_rr (
      .clock   (clock),
      .rst_n   (rst_n),
      .req     (req_vec),
      .advance (run_en),
      .grant   (grant)
   );

   assign gnt_any   = |grant;
   assign gnt_id    = grant[1];
   assign gnt_we    = grant[1] ? req_we_1    : req_we_0;
   assign gnt_addr  = grant[1] ? req_addr_1  : req_addr_0;
   assign gnt_wdata = grant[1] ? req_wdata_1 : req_wdata_0;

   assign req_ready_0 = grant[0];
   assign req_ready_1 = grant[1];
   assign init_done   = (state_reg == RUN);

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_address = addr_hold_reg;
      mem_dataIn  = data_hold_reg;
      tag_s1_next = '0;
      case (state_reg)
         INIT: begin
            mem_wr_en   = rst_n;
            mem_address = cnt_reg;
            mem_dataIn  = '0;
            cnt_next    = cnt_reg + 1'b1;
            if (cnt_reg == LAST_ADDR) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (clear) begin
               state_next = INIT;
               cnt_next   = '0;
            end else if (gnt_any) begin
               mem_address       = gnt_addr;
               mem_dataIn        = gnt_wdata;
               mem_rd_en         = !gnt_we;
               mem_wr_en         = gnt_we;
               tag_s1_next.valid = !gnt_we;
               tag_s1_next.id    = gnt_id;
            end
         end
         default: begin
            state_next = INIT;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_reg     <= INIT;
         cnt_reg       <= '0;
         addr_hold_reg <= '0;
         data_hold_reg <= '0;
         tag_s1_reg    <= '0;
         tag_s2_reg    <= '0;
         for (int k = 0; k < NUM_CLIENTS; k++) begin
            rsp_data_reg[k] <= '0;
         end
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         addr_hold_reg <= mem_address;
         data_hold_reg <= mem_dataIn;
         tag_s1_reg    <= tag_s1_next;
         tag_s2_reg    <= tag_s1_reg;
         for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (tag_s1_reg.valid && (tag_s1_reg.id == client_id_t'(k))) begin
               rsp_data_reg[k] <= mem_q;
            end
         end
      end
   end

   for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_rsp
      assign rsp_valid_vec[gi] = tag_s2_reg.valid && (tag_s2_reg.id == client_id_t'(gi));
   end

   assign rsp_valid_0 = rsp_valid_vec[0];
   assign rsp_valid_1 = rsp_valid_vec[1];
   assign rsp_data_0  = rsp_data_reg[0];
   assign rsp_data_1  = rsp_data_reg[1];

endmodule
